// File: rtl/pll_lock_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer_pkg
//   Shared definitions for the PLL lock sequencer:
//     - FSM state encodings. The SDRAM controller status logic decodes
//       state_dbg with the same encodings.
//     - state_dbg mapping helper.
//     - counter width helper used to size the shared cycle counter.
// -----------------------------------------------------------------------------
package pll_lock_sequencer_pkg;

    // State encodings as seen on state_dbg.
    localparam logic [2:0] ST_ENC_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_ENC_STABLE    = 3'd1;
    localparam logic [2:0] ST_ENC_POWERUP   = 3'd2;
    localparam logic [2:0] ST_ENC_RUN       = 3'd3;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = ST_ENC_WAIT_LOCK,
        ST_STABLE    = ST_ENC_STABLE,
        ST_POWERUP   = ST_ENC_POWERUP,
        ST_RUN       = ST_ENC_RUN
    } pll_seq_state_t;

    // Map an FSM state onto the 3-bit debug/status encoding.
    function automatic logic [2:0] state_dbg_of(input pll_seq_state_t s);
        return s;
    endfunction

    // Width of a counter that must hold 0 .. max(a,b)-1.
    // Never returns less than 1 so a zero-width vector cannot appear.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        if (m < 2) begin
            return 1;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
//   N-flop single-bit synchronizer with synchronous clear. Used for the PLL
//   LOCK input and reusable for downstream reset-deassertion synchronizers.
//
// Parameters
//   N       number of flops in the chain (must be >= 2)
// Ports
//   clk     destination clock
//   srst    synchronous active-high clear; all stages go to 0
//   d_in    asynchronous input bit
//   q_out   synchronized output (last stage of the chain)
// -----------------------------------------------------------------------------
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d_in,
    output logic q_out
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    // Stage 0 captures the asynchronous input; each later stage takes its
    // predecessor, giving an N-cycle delay.
    assign sync_d[0] = d_in;

    for (genvar gi = 1; gi < N; gi++) begin : g_stage
        assign sync_d[gi] = sync_q[gi-1];
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[N-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//   Supervises the PLL that clocks the SDRAM controller. Qualifies the PLL
//   LOCK signal, holds the system/SDRAM reset through the SDRAM power-up wait,
//   releases it with a one-cycle init_start pulse, and re-asserts it whenever
//   lock is lost (counting lock losses seen while running).
//   Runs on the free-running board reference clock, never on a PLL output.
//
// Parameters
//   LOCK_SYNC_STAGES  flops in the pll_locked synchronizer (>= 2)
//   LOCK_STABLE_CYC   consecutive synced-lock cycles before POWERUP (>= 1)
//   POWERUP_CYC       SDRAM power-up hold in clk cycles (>= 1)
//   LOSS_CNT_W        width of the saturating lock-loss counter
// Ports
//   clk            board reference clock
//   rst            synchronous active-high reset
//   pll_locked     PLL LOCK, asynchronous to clk
//   soft_rst_req   one-cycle request to re-run the power-up hold (RUN only)
//   sys_rst        reset to SDRAM controller/system, active high
//   init_start     one-cycle pulse on the first RUN cycle
//   ready          high while in RUN
//   lock_loss_cnt  lock losses seen in RUN, saturating at all-ones
//   state_dbg      current FSM state encoding
// -----------------------------------------------------------------------------
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int unsigned LOCK_SYNC_STAGES = 2,
    parameter int unsigned LOCK_STABLE_CYC  = 256,
    parameter int unsigned POWERUP_CYC      = 5000,
    parameter int unsigned LOSS_CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
    output logic                  sys_rst,
    output logic                  init_start,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]            state_dbg
);

    localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYC, POWERUP_CYC);

    // Terminal counts: the state is left on the edge that sees cnt at its
    // last value, so each state lasts exactly *_CYC cycles.
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYC - 1);

    // -------------------------------------------------------------------------
    // LOCK synchronizer
    // -------------------------------------------------------------------------
    logic lock_s;

    bit_sync #(
        .N (LOCK_SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .srst  (rst),
        .d_in  (pll_locked),
        .q_out (lock_s)
    );

    // -------------------------------------------------------------------------
    // State, counters and output registers
    // -------------------------------------------------------------------------
    pll_seq_state_t        state_q,       state_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic [LOSS_CNT_W-1:0] loss_q,        loss_d;
    logic                  sys_rst_q,     sys_rst_d;
    logic                  init_start_q,  init_start_d;
    logic                  ready_q,       ready_d;
    logic [2:0]            state_dbg_q,   state_dbg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            loss_q       <= '0;
            sys_rst_q    <= 1'b1;
            init_start_q <= 1'b0;
            ready_q      <= 1'b0;
            state_dbg_q  <= ST_ENC_WAIT_LOCK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_q       <= loss_d;
            sys_rst_q    <= sys_rst_d;
            init_start_q <= init_start_d;
            ready_q      <= ready_d;
            state_dbg_q  <= state_dbg_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, shared counter and loss counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = ST_STABLE;
                end
            end

            ST_STABLE: begin
                // Any low sample, even a single cycle, restarts qualification.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_POWERUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_POWERUP: begin
                // soft_rst_req is deliberately ignored: already holding reset.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == POWERUP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                // Lock loss takes priority over a simultaneous soft reset.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    if (loss_q != '1) begin
                        loss_d = loss_q + LOSS_CNT_W'(1);
                    end
                end else if (soft_rst_req) begin
                    // Lock is known good, so go straight to the power-up hold.
                    state_d = ST_POWERUP;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state so the registered outputs line up
    // with the state register (no extra cycle of latency).
    // -------------------------------------------------------------------------
    always_comb begin
        sys_rst_d    = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
        init_start_d = (state_d == ST_RUN) && (state_q != ST_RUN);
        state_dbg_d  = state_dbg_of(state_d);
    end

    assign sys_rst       = sys_rst_q;
    assign init_start    = init_start_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;
    assign state_dbg     = state_dbg_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Directed bench for pll_lock_sequencer with small parameters
//   (sync=2, stable=4, powerup=8, loss width=2). Expected values are
//   hand-derived latencies: after the first edge that samples pll_locked=1
//   from WAIT_LOCK (k=0), the state reads WAIT_LOCK for k=0..1, STABLE for
//   k=2..5, POWERUP for k=6..13 and RUN from k=14.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       sys_rst;
    logic       init_start;
    logic       ready;
    logic [1:0] lock_loss_cnt;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_loss[5] = '{1, 2, 3, 3, 3};

    pll_lock_sequencer #(
        .LOCK_SYNC_STAGES (2),
        .LOCK_STABLE_CYC  (4),
        .POWERUP_CYC      (8),
        .LOSS_CNT_W       (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .soft_rst_req  (soft_rst_req),
        .sys_rst       (sys_rst),
        .init_start    (init_start),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step through qualification indices k_first..k_last (k=0 is the first
    // edge sampling pll_locked=1 from WAIT_LOCK) checking all status outputs.
    task automatic qual_steps(input string tag, input int k_first, input int k_last);
        for (int k = k_first; k <= k_last; k++) begin
            int exp_dbg;
            step();
            exp_dbg = (k < 2) ? 0 : (k < 6) ? 1 : (k < 14) ? 2 : 3;
            check($sformatf("%s k=%0d state_dbg", tag, k), 32'(state_dbg), exp_dbg);
            check($sformatf("%s k=%0d sys_rst", tag, k), 32'(sys_rst), (k < 14) ? 1 : 0);
            check($sformatf("%s k=%0d ready", tag, k), 32'(ready), (k >= 14) ? 1 : 0);
            check($sformatf("%s k=%0d init_start", tag, k), 32'(init_start), (k == 14) ? 1 : 0);
        end
        $display("qual %s: k=%0d..%0d stepped, loss_cnt=%0d", tag, k_first, k_last, lock_loss_cnt);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step();
        step();
        check({tag, " rst sys_rst"}, 32'(sys_rst), 1);
        check({tag, " rst ready"}, 32'(ready), 0);
        check({tag, " rst init_start"}, 32'(init_start), 0);
        check({tag, " rst loss_cnt"}, 32'(lock_loss_cnt), 0);
        check({tag, " rst state_dbg"}, 32'(state_dbg), 0);
        rst = 1'b0;
        $display("reset %s: released", tag);
    endtask

    // Drop pll_locked from RUN at edge M; reset reasserts at M+2.
    task automatic lose_lock(input string tag, input int exp_cnt);
        pll_locked = 1'b0;
        step();
        check({tag, " M ready"}, 32'(ready), 1);
        check({tag, " M sys_rst"}, 32'(sys_rst), 0);
        step();
        check({tag, " M+1 ready"}, 32'(ready), 1);
        check({tag, " M+1 sys_rst"}, 32'(sys_rst), 0);
        step();
        check({tag, " M+2 sys_rst"}, 32'(sys_rst), 1);
        check({tag, " M+2 ready"}, 32'(ready), 0);
        check({tag, " M+2 state_dbg"}, 32'(state_dbg), 0);
        check({tag, " M+2 loss_cnt"}, 32'(lock_loss_cnt), exp_cnt);
        pll_locked = 1'b1;
        $display("lose_lock %s: loss_cnt=%0d", tag, lock_loss_cnt);
    endtask

    initial begin
        rst          = 1'b1;
        pll_locked   = 1'b1;
        soft_rst_req = 1'b0;

        // 1. Reset release with steady lock: RUN at k=14.
        do_reset("t1");
        qual_steps("t1", 0, 15);
        check("t1 loss_cnt", 32'(lock_loss_cnt), 0);

        // 5a. Soft reset in RUN: exactly 8 cycles of POWERUP, then RUN.
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        check("t5 K state_dbg", 32'(state_dbg), 2);
        check("t5 K ready", 32'(ready), 0);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) step();
            check($sformatf("t5 K+%0d sys_rst", j), 32'(sys_rst), 1);
        end
        step();
        check("t5 K+8 sys_rst", 32'(sys_rst), 0);
        check("t5 K+8 init_start", 32'(init_start), 1);
        check("t5 K+8 state_dbg", 32'(state_dbg), 3);
        step();
        check("t5 K+9 init_start", 32'(init_start), 0);
        check("t5 K+9 ready", 32'(ready), 1);
        check("t5 loss_cnt", 32'(lock_loss_cnt), 0);
        $display("soft_rst t5: done");

        // 3. Lock loss in RUN, then relock with a new init_start.
        lose_lock("t3", 1);
        qual_steps("t3 relock", 0, 15);
        check("t3 loss_cnt after relock", 32'(lock_loss_cnt), 1);

        // 5b. Lock loss and soft_rst_req reach the FSM on the same edge.
        pll_locked = 1'b0;
        step();
        step();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        check("t5b state_dbg", 32'(state_dbg), 0);
        check("t5b loss_cnt", 32'(lock_loss_cnt), 2);
        check("t5b sys_rst", 32'(sys_rst), 1);
        $display("soft_rst+loss t5b: state_dbg=%0d loss_cnt=%0d", state_dbg, lock_loss_cnt);
        pll_locked = 1'b1;
        qual_steps("t5b relock", 0, 15);

        // 6. Reset mid-POWERUP clears everything, sequence repeats.
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        step();
        step();
        check("t6 pre state_dbg", 32'(state_dbg), 2);
        rst = 1'b1;
        step();
        check("t6 sys_rst", 32'(sys_rst), 1);
        check("t6 ready", 32'(ready), 0);
        check("t6 loss_cnt", 32'(lock_loss_cnt), 0);
        check("t6 state_dbg", 32'(state_dbg), 0);
        rst = 1'b0;
        $display("reset t6: mid-POWERUP reset applied");
        qual_steps("t6", 0, 15);

        // 2. One-cycle lock glitch in STABLE (seen by the FSM at cnt==3).
        do_reset("t2");
        qual_steps("t2", 0, 3);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        check("t2 glitch state_dbg", 32'(state_dbg), 1);
        check("t2 glitch sys_rst", 32'(sys_rst), 1);
        step();
        check("t2 requal k=0 state_dbg", 32'(state_dbg), 1);
        qual_steps("t2 requal", 1, 15);
        check("t2 loss_cnt", 32'(lock_loss_cnt), 0);

        // 4. Five lock losses: counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            lose_lock($sformatf("t4 loss%0d", i + 1), exp_loss[i]);
            qual_steps($sformatf("t4 relock%0d", i + 1), 0, 14);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
